regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DBITS, default 32: register data width.
REQ-002 Parameter ABITS, default 4: register index width; WORDS = 2^ABITS.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 write request.
REQ-005 req0_ready  output  1  requester 0 accepted this cycle.
REQ-006 req0_ind  input  ABITS  requester 0 target register.
REQ-007 req0_data  input  DBITS  requester 0 write data.
REQ-008 req1_valid / req1_ready / req1_ind / req1_data SHALL match REQ-004..007 for requester 1.
REQ-009 rf_wrtEn  output  1  register file write enable.
REQ-010 rf_wrtInd  output  ABITS  register file write index.
REQ-011 rf_dIn  output  DBITS  register file write data.
REQ-012 grant  output  2  one-hot source of the current rf write: bit0 = req0, bit1 = req1; 00 for idle or sweep.
REQ-013 busy  output  1  clear sweep in progress.

Function
REQ-014 States SHALL be INIT (clear sweep) and ARB (arbitration); INIT is reachable only per REQ-026.
REQ-015 Transfer on requester n SHALL occur at a rising edge with reqn_valid=1 and reqn_ready=1.
REQ-016 Requester contract: once valid is asserted, valid, ind and data stay stable until the transfer occurs.
REQ-017 In ARB, reqn_ready SHALL be combinational: 1 when reqn_valid=1 and either the other requester is not valid or the priority pointer favours n.
REQ-018 At most one ready SHALL be 1 in any cycle; both SHALL be 0 in INIT.
REQ-019 Priority pointer: round-robin; after a req0 transfer it favours req1; after a req1 transfer it favours req0; otherwise unchanged.
REQ-020 A lone valid requester SHALL be granted every cycle (back-to-back, one write per clk).
REQ-021 Outputs rf_wrtEn, rf_wrtInd, rf_dIn and grant SHALL be registered: a transfer at edge k drives rf_wrtEn=1 with the accepted ind/data and grant bit during cycle k..k+1, and the register file writes at edge k+1.
REQ-022 On an edge with no transfer in ARB, rf_wrtEn SHALL go to 0 and grant to 00; rf_wrtInd and rf_dIn hold.
REQ-023 Requests to the same index from both requesters SHALL be serialized in grant order; the later write wins.

Reset
REQ-024 While reset_n=0: rf_wrtEn=0, rf_wrtInd=0, rf_dIn=0, grant=00, pointer favours req0, sweep counter=0, busy per REQ-026/027.
REQ-025 Reset asserted mid-sweep or mid-traffic SHALL abort immediately; a pending un-accepted request is not written.

Configuration
REQ-026 With REGFILE_INIT_CLEAR_EN defined: reset enters INIT with busy=1; each edge in INIT drives rf_wrtEn=1, rf_wrtInd=counter, rf_dIn=0, grant=00 and increments the counter; the edge issuing index WORDS-1 moves to ARB and clears busy (WORDS cycles total); reset during INIT restarts at index 0.
REQ-027 Without REGFILE_INIT_CLEAR_EN: reset enters ARB directly, busy is constant 0, and no sweep logic is present.

Verification
REQ-028 Macro on, release reset, both valid=1 -> 16 writes idx 0..15 data 0 on consecutive cycles, busy=1 for 16 cycles, both ready=0, then the first grant goes to req0.
REQ-029 ARB, req0 alone valid, idx 3, data 0xDEADBEEF -> req0_ready=1 the same cycle; next cycle rf_wrtEn=1, rf_wrtInd=3, rf_dIn=0xDEADBEEF, grant=01.
REQ-030 Both valid continuously (req0 idx 1, req1 idx 2) -> grants alternate 01,10,01,10; rf_wrtEn stays 1; the two ready signals are never both 1.
REQ-031 Both write idx 5 (req0 data 0xA, req1 data 0xB), pointer favours req1 -> rf writes 0xB then 0xA; final reg5=0xA.
REQ-032 reset_n pulsed low at sweep index 7 -> rf_wrtEn=0 immediately; after release the sweep restarts at idx 0 and takes the full 16 cycles.
REQ-033 Macro off, release reset -> busy=0 and req0_ready follows req0_valid in the first cycle; no zero writes are issued.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter in front of a register file, with registered write outputs.
// Define REGFILE_INIT_CLEAR_EN to zero every register with a sweep after each reset.
module regfile_write_arbiter #(
  parameter int DBITS = 32,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ABITS-1:0] req0_ind,
  input  logic [DBITS-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ABITS-1:0] req1_ind,
  input  logic [DBITS-1:0] req1_data,
  output logic             rf_wrtEn,
  output logic [ABITS-1:0] rf_wrtInd,
  output logic [DBITS-1:0] rf_dIn,
  output logic [1:0]       grant,
  output logic             busy
);

  logic             in_arb;
  logic             ptr_q, ptr_d;      // 0: req0 favoured, 1: req1 favoured
  logic             wen_q, wen_d;
  logic [ABITS-1:0] ind_q, ind_d;
  logic [DBITS-1:0] din_q, din_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             xfer0, xfer1;

`ifdef REGFILE_INIT_CLEAR_EN
  localparam int WORDS = 2 ** ABITS;
  typedef enum logic {S_INIT, S_ARB} state_e;
  state_e           state_q;
  logic [ABITS-1:0] cnt_q;

  assign in_arb = (state_q == S_ARB);
  assign busy   = (state_q == S_INIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else if (state_q == S_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == ABITS'(WORDS - 1)) state_q <= S_ARB;
    end
  end
`else
  assign in_arb = 1'b1;
  assign busy   = 1'b0;
`endif

  assign req0_ready = in_arb & req0_valid & (~req1_valid | ~ptr_q);
  assign req1_ready = in_arb & req1_valid & (~req0_valid |  ptr_q);
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  always_comb begin
    wen_d = 1'b0;
    ind_d = ind_q;
    din_d = din_q;
    gnt_d = 2'b00;
    ptr_d = ptr_q;
    if (xfer0) begin
      wen_d = 1'b1;
      ind_d = req0_ind;
      din_d = req0_data;
      gnt_d = 2'b01;
      ptr_d = 1'b1;
    end else if (xfer1) begin
      wen_d = 1'b1;
      ind_d = req1_ind;
      din_d = req1_data;
      gnt_d = 2'b10;
      ptr_d = 1'b0;
    end
`ifdef REGFILE_INIT_CLEAR_EN
    // Sweep writes zero to the counter index; readies are low so no transfer competes.
    if (!in_arb) begin
      wen_d = 1'b1;
      ind_d = cnt_q;
      din_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wen_q <= 1'b0;
      ind_q <= '0;
      din_q <= '0;
      gnt_q <= 2'b00;
      ptr_q <= 1'b0;
    end else begin
      wen_q <= wen_d;
      ind_q <= ind_d;
      din_q <= din_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign rf_wrtEn  = wen_q;
  assign rf_wrtInd = ind_q;
  assign rf_dIn    = din_q;
  assign grant     = gnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; follows REGFILE_INIT_CLEAR_EN if defined.
module tb_regfile_write_arbiter;
  localparam int DBITS = 32;
  localparam int ABITS = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [ABITS-1:0] req0_ind, req1_ind;
  logic [DBITS-1:0] req0_data, req1_data;
  logic             rf_wrtEn;
  logic [ABITS-1:0] rf_wrtInd;
  logic [DBITS-1:0] rf_dIn;
  logic [1:0]       grant;
  logic             busy;

  int errors = 0;
  int checks = 0;
  logic [DBITS-1:0] rf_model [2**ABITS];

  regfile_write_arbiter #(.DBITS(DBITS), .ABITS(ABITS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ind(req0_ind), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ind(req1_ind), .req1_data(req1_data),
    .rf_wrtEn(rf_wrtEn), .rf_wrtInd(rf_wrtInd), .rf_dIn(rf_dIn), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file that the arbiter feeds.
  always @(posedge clk) if (rf_wrtEn) rf_model[rf_wrtInd] <= rf_dIn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_out(input string tag, input logic en, input logic [ABITS-1:0] ind,
                        input logic [DBITS-1:0] d, input logic [1:0] g);
    chk({tag, ".en"}, 64'(rf_wrtEn), 64'(en));
    chk({tag, ".ind"}, 64'(rf_wrtInd), 64'(ind));
    chk({tag, ".din"}, 64'(rf_dIn), 64'(d));
    chk({tag, ".grant"}, 64'(grant), 64'(g));
  endtask

`ifdef REGFILE_INIT_CLEAR_EN
  // Runs a full sweep from just after reset release; both requesters held valid.
  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      chk({tag, ".rdy"}, 64'({req0_ready, req1_ready}), 64'd0);
      tick();
      wr_out($sformatf("%s.w%0d", tag, i), 1'b1, ABITS'(i), '0, 2'b00);
    end
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_ind = '0; req0_data = '0;
    req1_valid = 1'b0; req1_ind = '0; req1_data = '0;
    #12;
    wr_out("reset", 1'b0, '0, '0, 2'b00);

`ifdef REGFILE_INIT_CLEAR_EN
    chk("reset.busy", 64'(busy), 64'd1);
    req0_valid = 1'b1; req0_ind = 4'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_ind = 4'd2; req1_data = 32'h22;
    @(negedge clk); reset_n = 1'b1; #1;
    sweep("sweep");
    chk("post_sweep.rdy", 64'({req0_ready, req1_ready}), 64'b10);
    tick();
    wr_out("post_sweep.first", 1'b1, 4'd1, 32'h11, 2'b01);
    // Abort a second sweep at index 7.
    reset_n = 1'b0; #2; reset_n = 1'b1; #1;
    for (int i = 0; i < 8; i++) tick();
    chk("mid.ind7", 64'(rf_wrtInd), 64'd7);
    reset_n = 1'b0; #1;
    wr_out("mid.abort", 1'b0, '0, '0, 2'b00);
    @(negedge clk); reset_n = 1'b1; #1;
    sweep("resweep");
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
`else
    chk("reset.busy", 64'(busy), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    req0_valid = 1'b1; req0_ind = 4'd3; req0_data = 32'hDEADBEEF; #1;
    chk("first.rdy0", 64'(req0_ready), 64'd1);
    chk("first.rdy1", 64'(req1_ready), 64'd0);
    chk("first.busy", 64'(busy), 64'd0);
`endif

    // Lone req0 write; pointer moves to req1.
    reset_n = 1'b1;
    req0_valid = 1'b1; req0_ind = 4'd3; req0_data = 32'hDEADBEEF; #1;
    chk("lone0.rdy", 64'({req0_ready, req1_ready}), 64'b10);
    tick();
    req0_valid = 1'b0;
    wr_out("lone0", 1'b1, 4'd3, 32'hDEADBEEF, 2'b01);
    tick();
    wr_out("idle", 1'b0, 4'd3, 32'hDEADBEEF, 2'b00);

    // Contention: pointer favours req1, so grants go 10,01,10,01.
    req0_valid = 1'b1; req0_ind = 4'd1; req0_data = 32'h0101;
    req1_valid = 1'b1; req1_ind = 4'd2; req1_data = 32'h0202;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d.rdy", i), 64'({req0_ready, req1_ready}), (i % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      if (i % 2 == 0) wr_out($sformatf("rr%0d", i), 1'b1, 4'd2, 32'h0202, 2'b10);
      else            wr_out($sformatf("rr%0d", i), 1'b1, 4'd1, 32'h0101, 2'b01);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Same index from both, pointer favours req1: 0xB lands first, then 0xA.
    req0_valid = 1'b1; req0_ind = 4'd5; req0_data = 32'hA;
    req1_valid = 1'b1; req1_ind = 4'd5; req1_data = 32'hB;
    tick();
    req1_valid = 1'b0;
    wr_out("same.first", 1'b1, 4'd5, 32'hB, 2'b10);
    tick();
    req0_valid = 1'b0;
    wr_out("same.second", 1'b1, 4'd5, 32'hA, 2'b01);
    tick();
    chk("same.reg5", 64'(rf_model[5]), 64'hA);

    // Lone req1 back-to-back, new index each transfer.
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_ind = ABITS'(7 + i); req1_data = 32'h100 + i; #1;
      chk($sformatf("b2b%0d.rdy1", i), 64'(req1_ready), 64'd1);
      tick();
      wr_out($sformatf("b2b%0d", i), 1'b1, ABITS'(7 + i), 32'h100 + i, 2'b10);
    end
    req1_valid = 1'b0;

    // Reset mid-traffic: outputs clear at once, pending request not written.
    req0_valid = 1'b1; req0_ind = 4'd12; req0_data = 32'hCAFE;
    tick();
    wr_out("pre_rst", 1'b1, 4'd12, 32'hCAFE, 2'b01);
    req0_data = 32'hBAD; req1_valid = 1'b1; req1_ind = 4'd13; req1_data = 32'hBAD;
    #2 reset_n = 1'b0; #1;
    wr_out("rst_abort", 1'b0, '0, '0, 2'b00);
    chk("rst_abort.rdy", 64'({req0_ready, req1_ready}),
`ifdef REGFILE_INIT_CLEAR_EN
        64'b00);
`else
        64'b10);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    tick();
    chk("rst_abort.reg13", 64'(rf_model[13] === 32'hBAD), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
